// File: rtl/fsm_seq_ctrl.sv
// Hardware sequencer for the 4-bit state FSM: pulses its reset, plays a latched
// w pattern one bit per step and counts step-end samples of z that hit a target.
module fsm_seq_ctrl #(
    parameter int MAX_LEN     = 16,
    parameter int LEN_W       = 5,
    parameter int STEP_CYCLES = 2,
    parameter int RST_CYCLES  = 2,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic [3:0]         target,
    input  logic [3:0]         z_in,
    output logic               w_out,
    output logic               fsm_reset,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   hit_count,
    output logic [3:0]         last_z,
    output logic [1:0]         state_dbg
);

    // Handshake: start is a one-cycle request honoured only in IDLE (it wins over
    // abort there); abort is honoured only outside IDLE; done is a one-cycle pulse.
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam int CMAX  = (RST_CYCLES > STEP_CYCLES) ? RST_CYCLES : STEP_CYCLES;
    localparam int CYC_W = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CYC_W-1:0] RST_LAST  = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] STEP_LAST = CYC_W'(STEP_CYCLES - 1);

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [3:0]         tgt_q;
    logic [LEN_W-1:0]   idx;
    logic [CYC_W-1:0]   cyc;
    logic               out_en;

    logic [LEN_W-1:0]   len_clamped;
    logic               step_end;
    logic               last_step;
    logic [MAX_LEN-1:0] pat_shift;

    assign len_clamped = (length > MAX_LEN_L) ? MAX_LEN_L : length;
    assign step_end    = (state == RUN) && (cyc == STEP_LAST);
    assign last_step   = (idx == len_q - LEN_W'(1));
    assign pat_shift   = pat_q >> idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (len_clamped != '0) ? CLEAR : DONE;
            CLEAR: begin
                if (abort)                 state_nxt = IDLE;
                else if (cyc == RST_LAST)  state_nxt = RUN;
            end
            RUN: begin
                if (abort)                      state_nxt = IDLE;
                else if (step_end && last_step) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_en keeps the FSM in reset while this block is in reset, without a
    // combinational path from the reset pin to fsm_reset.
    assign fsm_reset = out_en && (state != CLEAR);
    assign w_out     = (state == RUN) ? pat_shift[0] : 1'b0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_en    <= 1'b0;
            pat_q     <= '0;
            len_q     <= '0;
            tgt_q     <= '0;
            idx       <= '0;
            cyc       <= '0;
            hit_count <= '0;
            last_z    <= '0;
        end else begin
            out_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q     <= pattern;
                        len_q     <= len_clamped;
                        tgt_q     <= target;
                        idx       <= '0;
                        cyc       <= '0;
                        hit_count <= '0;
                        last_z    <= '0;
                    end
                end
                CLEAR: begin
                    if (!abort) cyc <= (cyc == RST_LAST) ? '0 : cyc + CYC_W'(1);
                end
                RUN: begin
                    if (!abort) begin
                        if (step_end) begin
                            last_z <= z_in;
                            if (z_in == tgt_q && hit_count != '1)
                                hit_count <= hit_count + CNT_W'(1);
                            cyc <= '0;
                            idx <= idx + LEN_W'(1);
                        end else begin
                            cyc <= cyc + CYC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: directed and random runs checked cycle by cycle against
// a timing model derived from the start/step/done latency rules.
module tb_fsm_seq_ctrl;
    localparam int R = 2;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic [3:0]  target, z_in;

    logic        w_out, fsm_reset, busy, done;
    logic [4:0]  hit_count;
    logic [3:0]  last_z;
    logic [1:0]  st;

    logic        w2, fr2, busy2, done2;
    logic [1:0]  hit2;
    logic [3:0]  lz2;
    logic [1:0]  st2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] fz = 4'd0;
    logic [3:0] z_hist [0:127];

    always #5 clk = ~clk;

    fsm_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
        .length(length), .target(target), .z_in(z_in), .w_out(w_out),
        .fsm_reset(fsm_reset), .busy(busy), .done(done), .hit_count(hit_count),
        .last_z(last_z), .state_dbg(st)
    );

    fsm_seq_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
        .length(length), .target(target), .z_in(z_in), .w_out(w2),
        .fsm_reset(fr2), .busy(busy2), .done(done2), .hit_count(hit2),
        .last_z(lz2), .state_dbg(st2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run, starting with start=1 at offset 0. ab: offset of abort (-1 none,
    // 0 = together with start); rs: offset of a stray start; tail: idle cycles after.
    task automatic run(input logic [15:0] pat, input logic [4:0] len, input logic [3:0] tgt,
                       input bit zrand, input int ab, input int rs, input int tail);
        int l, done_off, last_off, h, e;
        bit aborted, idle;
        logic [3:0] zv, lz;
        logic w_e, frst_e;
        l        = (len > 5'd16) ? 16 : int'(len);
        done_off = (l == 0) ? 1 : R + l * S + 1;
        aborted  = (ab >= 1) && (ab <= done_off);
        last_off = aborted ? ab + 1 + tail : done_off + tail;
        for (int o = 0; o <= last_off; o++) begin
            @(negedge clk);
            if (o == 0) begin
                start = 1'b1; abort = (ab == 0);
                pattern = pat; length = len; target = tgt;
            end else begin
                start = (o == rs); abort = (o == ab);
                pattern = 16'($urandom); length = 5'($urandom); target = 4'($urandom);
            end
            zv = zrand ? (($urandom_range(0, 2) == 0) ? tgt : 4'($urandom_range(0, 15))) : fz;
            z_in = zv;
            z_hist[o] = zv;
            #1;
            if (o >= 1) begin
                idle   = (aborted && o > ab) || (o > done_off);
                frst_e = !(!idle && l != 0 && o <= R);
                w_e    = (!idle && l != 0 && o > R && o < done_off) ? pat[(o - R - 1) / S] : 1'b0;
                h = 0; lz = 4'd0;
                for (int j = 0; j < l; j++) begin
                    e = R + (j + 1) * S;
                    if (e < o && (!aborted || e < ab)) begin
                        if (z_hist[e] == tgt) h++;
                        lz = z_hist[e];
                    end
                end
                chk("w_out", w_out, w_e);
                chk("fsm_reset", fsm_reset, frst_e);
                chk("busy", busy, !idle);
                chk("done", done, !idle && o == done_off);
                chk("hit_count", hit_count, (h > 31) ? 31 : h);
                chk("last_z", last_z, lz);
                chk("hit_count_sat", hit2, (h > 3) ? 3 : h);
                chk("done_w2", done2, !idle && o == done_off);
            end
            if (!fsm_reset) fz = 4'd0;
            else            fz = w_out ? ((fz == 4'd9) ? 4'd0 : fz + 4'd1) : 4'd0;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        pattern = '0; length = '0; target = '0; z_in = '0;
        #1;
        chk("rst_w_out", w_out, 0);
        chk("rst_fsm_reset", fsm_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_last_z", last_z, 0);
        chk("rst_state", st, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_fsm_reset", fsm_reset, 1);
        chk("idle_busy", busy, 0);

        run(16'h0000, 5'd5, 4'd0, 1'b0, -1, -1, 2);                      // basic, idle code target
        run(16'h002A, 5'd6, 4'($urandom_range(0, 2)), 1'b0, -1, -1, 1);  // alternating
        run(16'h1234, 5'd0, 4'd5, 1'b1, -1, -1, 2);                      // zero length
        run(16'($urandom), 5'd20, 4'($urandom), 1'b1, -1, -1, 1);        // clamp to 16
        run(16'hBEEF, 5'd8, 4'd3, 1'b1, -1, R + 3 * S + 1, 1);           // stray start at step 3
        run(16'h5A5A, 5'd8, 4'd7, 1'b1, R + 2 * S + 1, -1, 2);           // abort at step 2
        run(16'h00FF, 5'd4, 4'd2, 1'b1, 0, -1, 0);                       // start+abort in IDLE
        run(16'h0F0F, 5'd5, 4'd9, 1'b1, -1, -1, 1);                      // back-to-back start
        run(16'h3C3C, 5'd3, 4'd1, 1'b1, R + 3 * S + 1, -1, 1);           // abort in DONE
        for (int n = 0; n < 6; n++)
            run(16'($urandom), 5'($urandom_range(0, 20)), 4'($urandom), 1'($urandom),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1, -1,
                int'($urandom_range(0, 2)));

        // reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; pattern = 16'hFFFF; length = 5'd8; target = 4'd0; z_in = 4'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_w_out", w_out, 0);
        chk("midrst_fsm_reset", fsm_reset, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hit", hit_count, 0);
        chk("midrst_last_z", last_z, 0);
        chk("midrst_hit_sat", hit2, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_fsm_reset", fsm_reset, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_w_out", w_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
Sequencer that exercises the 4-bit state FSM in hardware, replacing the bench-style driving of w.
- On start it pulses the FSM's active-low reset, then plays a programmed bit pattern onto w, one bit per step.
- At the end of each step it samples the FSM state z and counts matches against a target state.
- Sits between a host or CPU register block and one FSM instance.

Parameters:
MAX_LEN, 16, maximum pattern length in steps (bits)
LEN_W, 5, width of length input; must hold MAX_LEN
STEP_CYCLES, 2, clock cycles each w bit is held (>=1)
RST_CYCLES, 2, cycles fsm_reset is held low before the first step (>=1)
CNT_W, 5, width of hit_count (saturating)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a run; sampled only in IDLE
abort  in  1  cancel the run in progress; ignored in IDLE
pattern  in  MAX_LEN  w bit sequence, bit 0 played first; latched at start
length  in  LEN_W  number of steps; latched at start; clamped to MAX_LEN
target  in  4  state code to count; latched at start
z_in  in  4  state output from the FSM
w_out  out  1  drives the FSM's w input
fsm_reset  out  1  drives the FSM's active-low reset
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse at run completion (not on abort)
hit_count  out  CNT_W  number of step samples where z_in == target
last_z  out  4  z_in captured at the most recent step sample

Behaviour:
- Async reset (reset=0):
  - state=IDLE; w_out=0; fsm_reset=0 (FSM held in reset while the controller is in reset).
  - busy=0, done=0, hit_count=0, last_z=0; latched registers cleared.
- States are IDLE, CLEAR, RUN, DONE.
- IDLE:
  - fsm_reset=1, w_out=0.
  - start=1 latches pattern, target and the clamped length; loads the step index to 0.
  - Next state: CLEAR if length!=0, else DONE.
  - hit_count and last_z clear to 0 on the start edge.
- CLEAR:
  - fsm_reset=0 for exactly RST_CYCLES cycles; w_out=0; busy=1.
  - Then go to RUN with the cycle counter at 0.
- RUN:
  - fsm_reset=1; w_out = pattern_latched[idx], held constant for STEP_CYCLES cycles.
  - On the final cycle of each step: last_z<=z_in; if z_in==target, hit_count<=hit_count+1, saturating at 2^CNT_W-1.
  - idx increments; when idx reaches length-1 on that edge, go to DONE.
- DONE:
  - Held for one cycle: done=1, busy=1, w_out=0, fsm_reset=1.
  - Next state is IDLE.
- Latency:
  - start accepted at edge k.
  - fsm_reset low for cycles k+1 .. k+RST_CYCLES.
  - Step j occupies cycles k+1+RST_CYCLES+j*STEP_CYCLES onward.
  - done is high in cycle k+1+RST_CYCLES+length*STEP_CYCLES.
  - For length=0: done is high in cycle k+1, no FSM reset pulse, hit_count=0.
- start while busy: ignored; latched values are not disturbed.
- start and abort together in IDLE: start is taken and abort is ignored.
- abort in CLEAR, RUN or DONE:
  - Next state IDLE; fsm_reset=1, w_out=0, busy=0, done=0.
  - hit_count and last_z keep their current values.
  - An abort in DONE does not suppress the done already asserted in that cycle.
- Reset mid-run: immediate return to IDLE reset values; the FSM is forced into reset via fsm_reset=0 until reset releases.
- length > MAX_LEN: treated as MAX_LEN.
- Inputs are synchronous to clk; z_in is sampled only on step-end edges.

Test Plan:
- Reset check: reset=0 mid-run in RUN → next sample w_out=0, fsm_reset=0, busy=0, hit_count=0; after release, fsm_reset=1 in IDLE.
- Basic run, defaults: length=5, pattern=5'b00000, target=FSM idle code → fsm_reset low exactly 2 cycles after start; w_out=0 for 10 cycles; done pulses once, 13 cycles after the start edge; hit_count=5.
- Alternating pattern: length=6, pattern=6'b101010 → w_out sequence 0,1,0,1,0,1, each held 2 cycles; last_z equals z_in at the final step edge; hit_count equals the model-predicted match count.
- Boundaries:
  - length=0 → done in the cycle after start, no fsm_reset pulse, hit_count=0.
  - length=20 → behaves as 16 steps.
  - CNT_W=2 with 5 matches → hit_count saturates at 3.
- Handshake:
  - start pulsed at step 3 of a run → ignored; run completes with the original pattern.
  - abort at step 2 → busy drops the next cycle, no done, hit_count holds its partial value.
- Back-to-back: start asserted in the cycle after done → a new run is accepted, hit_count clears, and FSM reset is pulsed again.
